// File: rtl/nibble_serial_tx_pkg.sv
// Shared definitions for the nibble serial link: FSM state encodings and line levels.
// The matching receiver imports the same package so both ends agree on encodings.
package nibble_serial_tx_pkg;

  // Frame phases; the encodings are fixed so the receiver can decode them identically.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Level the serial line rests at between frames (also the stop-bit level).
  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period timer: counts enabled cycles 0..CLKS_PER_BIT-1 and flags the last one.
module nibble_serial_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic Ce,
  input  logic clr,
  output logic tick
);

  // A 1-cycle bit period still needs a one-bit counter that simply stays at zero.
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == CntLast);
  // Only an enabled cycle can finish a bit period.
  assign tick    = Ce & at_last;

  // Next count: hold at zero while cleared, wrap after the last cycle of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register, frozen when Ce is low; reset wins over Ce.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (Ce) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Serial transmitter: start(0), DATA_W bits LSB-first, optional even parity, stop(1).
module nibble_serial_tx
  import nibble_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Ce,
  input  logic [DATA_W-1:0] Din,
  input  logic              Load,
  output logic              Ready,
  output logic              TxD,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DATA_W - 1);

  tx_state_e           state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                parity_q, parity_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
  logic                timer_clr;
  logic                accept;

  assign Ready     = (state_q == StIdle);
  assign accept    = Load & Ready & Ce;
  // Keep the period counter at zero while idle so START gets a full period.
  assign timer_clr = (state_q == StIdle);

  assign TxD  = txd_q;
  assign Busy = busy_q;
  assign Done = done_q;

  nibble_serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK (CLK),
    .RST (RST),
    .Ce  (Ce),
    .clr (timer_clr),
    .tick(tick)
  );

  // Next-state and output decode; TxD is loaded with the level of the bit being entered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StStart;
          shift_d   = Din;
          parity_d  = ^Din;
          bit_cnt_d = '0;
          txd_d     = LineStart;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              state_d = StStop;
              txd_d   = LineIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          txd_d   = LineIdle;
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          txd_d   = LineIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = LineIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; Ce low freezes everything, reset ignores Ce.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= LineIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (Ce) begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench: each accepted frame pushes its expected per-cycle line waveform.
module tb_nibble_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ce;
  logic       ce_toggle;
  logic       chk_en;
  logic [3:0] din;
  logic [2:0] load;
  logic [2:0] ready, txd, busy, done;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          cur = 0;
  int          accept_cnt = 0;

  // Expected {txd, busy, done} for each enabled cycle of the active instance.
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur = 3'b100;

  // Instance 0: plain frame, 1: with parity, 2: parity with one-cycle bits.
  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
    .CLK(clk), .RST(rst), .Ce(ce), .Din(din), .Load(load[0]),
    .Ready(ready[0]), .TxD(txd[0]), .Busy(busy[0]), .Done(done[0])
  );
  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
    .CLK(clk), .RST(rst), .Ce(ce), .Din(din), .Load(load[1]),
    .Ready(ready[1]), .TxD(txd[1]), .Busy(busy[1]), .Done(done[1])
  );
  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut2 (
    .CLK(clk), .RST(rst), .Ce(ce), .Din(din), .Load(load[2]),
    .Ready(ready[2]), .TxD(txd[2]), .Busy(busy[2]), .Done(done[2])
  );

  function automatic int cpb_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit par_of(input int i);
    return (i != 0);
  endfunction

  // Expand a word into its line levels, each repeated for one bit period, then the Done cycle.
  function automatic void push_frame(input logic [3:0] d, input int i);
    logic seq[$];
    seq.push_back(1'b0);
    for (int b = 0; b < 4; b++) seq.push_back(d[b]);
    if (par_of(i)) seq.push_back(^d);
    seq.push_back(1'b1);
    foreach (seq[k]) begin
      for (int c = 0; c < cpb_of(i); c++) exp_q.push_back({seq[k], 1'b1, 1'b0});
    end
    exp_q.push_back(3'b101);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: accept when the model is idle, Load is high and Ce is high.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_cur <= 3'b100;
    end else if (ce) begin
      if (exp_q.size() == 0 && load[cur]) begin
        push_frame(din, cur);
        accept_cnt <= accept_cnt + 1;
      end
      exp_cur <= (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
    end
  end

  // Compare all instances on the falling edge, then drive the next cycle's Ce.
  task automatic step();
    logic [31:0] got_v, exp_v;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        got_v = {28'd0, ready[i], txd[i], busy[i], done[i]};
        if (i == cur) exp_v = {28'd0, (exp_q.size() == 0), exp_cur};
        else          exp_v = {28'd0, 4'b1100};
        check_eq($sformatf("dut%0d {rdy,txd,busy,done} @%0t", i, $time), got_v, exp_v);
      end
    end
    @(posedge clk);
    #2;
    ce = ce_toggle ? ~ce : 1'b1;
  endtask

  task automatic wait_accept(input int n, input int budget);
    int k = 0;
    while (accept_cnt < n && k < budget) begin
      step();
      k++;
    end
    if (accept_cnt < n) check_eq("accept timeout", 32'(accept_cnt), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && exp_cur == 3'b100) && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) check_eq("idle timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [3:0] d);
    din = d;
    load[cur] = 1'b1;
    wait_accept(accept_cnt + 1, 40);
    load[cur] = 1'b0;
    din = ~d;
  endtask

  task automatic reset_to(input int i);
    load = '0;
    rst  = 1'b0;
    cur  = i;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1; ce_toggle = 1'b0; chk_en = 1'b0; din = '0; load = '0;
    step();
    chk_en = 1'b1;

    // Reset held with Load high everywhere; nothing may go out after release.
    load = 3'b111; din = 4'hA;
    repeat (3) step();
    rst = 1'b1; load = '0;
    repeat (12) step();

    // Plain frame, 4 clocks per bit.
    send(4'hA);
    wait_idle(60);
    repeat (3) step();

    // Same frame with Ce toggling; Load kept high while busy must be ignored.
    ce_toggle = 1'b1; din = 4'hA; load[0] = 1'b1;
    wait_accept(accept_cnt + 1, 20);
    repeat (10) step();
    load[0] = 1'b0;
    wait_idle(120);
    ce_toggle = 1'b0;
    repeat (3) step();

    // Reset during the second data bit, then a clean frame.
    send(4'h5);
    repeat (9) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (5) step();
    send(4'h6);
    wait_idle(60);
    repeat (2) step();

    // Parity frames and back-to-back sends.
    reset_to(1);
    send(4'h7);
    wait_idle(60);
    send(4'hA);
    wait_idle(60);
    din = 4'h3; load[1] = 1'b1;
    wait_accept(accept_cnt + 1, 20);
    din = 4'hC;
    wait_accept(accept_cnt + 1, 60);
    load[1] = 1'b0;
    wait_idle(60);
    repeat (2) step();

    // One clock per bit.
    reset_to(2);
    send(4'hA);
    wait_idle(20);
    din = 4'h7; load[2] = 1'b1;
    wait_accept(accept_cnt + 1, 10);
    din = 4'h9;
    wait_accept(accept_cnt + 1, 20);
    load[2] = 1'b0;
    wait_idle(20);
    ce_toggle = 1'b1;
    send(4'hC);
    wait_idle(40);
    ce_toggle = 1'b0;
    repeat (2) step();
    send(4'hF);
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();
    send(4'h1);
    wait_idle(20);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
